// File: rtl/core_pkg.sv
// Shared definitions for the core front end: data width, fetch FSM states and
// the fixed instruction/address constants used by the fetch stage.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_KILL  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load of a redirect target wins over the +4
// increment; otherwise the PC holds.
module fetch_pc_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // NOTE: default assigned first so every path drives pc_d and no latch is inferred.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (inc) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // NOTE: non-blocking assignments in clocked processes so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem request/ack handshake, instruction register,
// stall and redirect handling. Optional FETCH_MISALIGN_TRAP_EN halts on misaligned redirects.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  output logic            misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] kill_addr_q, kill_addr_d;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tgt_pc;
  logic            pc_load;
  logic            pc_inc;
  logic            ack_v;
  logic            halt;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst),
    .load    (pc_load),
    .load_pc (tgt_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_KILL);
  // The killed request must keep its address until memory answers it.
  assign imem_addr = (state_q == S_KILL) ? kill_addr_q : pc;
  assign ack_v     = imem_ack & imem_req;
  assign tgt_pc    = redirect_pc & ~XLEN'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign halt     = misalign_q;
  assign misalign = misalign_q;
`else
  assign halt     = 1'b0;
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    kill_addr_d = kill_addr_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (ack_v) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc;
          valid_d    = 1'b1;
          pc_inc     = 1'b1;
          state_d    = stall ? S_HOLD : S_FETCH;
        end else if (valid_q && !stall) begin
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_KILL: begin
        if (ack_v) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything above; an in-flight request is drained in S_KILL.
    if (redirect) begin
      pc_load = 1'b1;
      pc_inc  = 1'b0;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (state_q == S_FETCH && !ack_v) begin
        state_d     = S_KILL;
        kill_addr_d = pc;
      end else if (state_q != S_KILL) begin
        state_d = S_FETCH;
      end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
      state_d    = S_IDLE;
    end
    if (misalign_q) state_d = S_IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= '0;
      valid_q     <= 1'b0;
      kill_addr_q <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      valid_q     <= valid_d;
      kill_addr_q <= kill_addr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign instr       = valid_q ? instr_q : NOP_INSTR;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = instr_pc_q + XLEN'(4);
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable instruction memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 0;
  int          wait_cnt = 0;
  logic        ack_force;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  // Memory answers after `lat` wait cycles; data word encodes its address.
  assign imem_ack   = ack_force | (imem_req & (wait_cnt >= lat));
  assign imem_rdata = 32'hA000_0000 | imem_addr;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(imem_req),    32'd0);
    check({tag, "_addr"},  imem_addr,        32'h0);
    check({tag, "_instr"}, instr,            NOP);
    check({tag, "_ipc"},   instr_pc,         32'h0);
    check({tag, "_pc4"},   pc_plus4,         32'h4);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_mis"},   32'(misalign),    32'd0);
  endtask

  // Leaves the bench in cycle 1 after release (S_IDLE).
  task automatic do_reset(input int l);
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    ack_force   = 1'b0;
    lat         = l;
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b1;
    check("idle_req", 32'(imem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;

    // Zero-wait memory: one instruction per cycle from RESET_PC.
    do_reset(0);
    tick();
    check("c2_req",  32'(imem_req), 32'd1);
    check("c2_addr", imem_addr,     32'h0);
    check("c2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("c3_valid", 32'(instr_valid), 32'd1);
    check("c3_ipc",   instr_pc,         32'h0);
    check("c3_instr", instr,            32'hA000_0000);
    check("c3_pc4",   pc_plus4,         32'h4);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("stream_valid", 32'(instr_valid), 32'd1);
      check("stream_ipc",   instr_pc,         32'(4 * k));
    end
    check("stream_pc4", pc_plus4, 32'h10);

    // Switch to 3 wait cycles: address held 4 cycles, one valid pulse per 4 cycles.
    lat = 3;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        check("lat_addr",  imem_addr,        32'(16 + 4 * p));
        check("lat_valid", 32'(instr_valid), (i == 0) ? 32'd1 : 32'd0);
        if (i == 0) check("lat_ipc", instr_pc, 32'(12 + 4 * p));
        tick();
      end
    end
    check("lat_end_valid", 32'(instr_valid), 32'd1);
    check("lat_end_ipc",   instr_pc,         32'h14);

    // Stall for 5 cycles while the 0x10 instruction is held.
    do_reset(0);
    repeat (5) tick();
    check("stall_pre_addr", imem_addr, 32'h10);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_req",   32'(imem_req),    32'd0);
      check("hold_ipc",   instr_pc,         32'h10);
      check("hold_instr", instr,            32'hA000_0010);
      check("hold_valid", 32'(instr_valid), 32'd1);
    end
    tick();
    stall = 1'b0;
    check("hold_last_req",   32'(imem_req),    32'd0);
    check("hold_last_valid", 32'(instr_valid), 32'd1);
    tick();
    check("resume_req",   32'(imem_req),    32'd1);
    check("resume_addr",  imem_addr,        32'h14);
    check("resume_valid", 32'(instr_valid), 32'd0);
    tick();
    check("resume_ipc",   instr_pc,         32'h14);
    check("resume_valid2", 32'(instr_valid), 32'd1);

    // Redirect while the 0x20 fetch is outstanding.
    do_reset(3);
    guard = 0;
    while (imem_addr != 32'h20 && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_0x20", imem_addr, 32'h20);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("kill_req",   32'(imem_req),    32'd1);
    check("kill_addr",  imem_addr,        32'h20);
    check("kill_valid", 32'(instr_valid), 32'd0);
    check("kill_instr", instr,            NOP);
    tick();
    tick();
    check("kill_addr_ack", imem_addr, 32'h20);
    tick();
    check("post_kill_addr",  imem_addr,        32'h100);
    check("post_kill_valid", 32'(instr_valid), 32'd0);
    check("post_kill_instr", instr,            NOP);
    guard = 0;
    while (!instr_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("redir_valid", 32'(instr_valid), 32'd1);
    check("redir_ipc",   instr_pc,         32'h100);
    check("redir_instr", instr,            32'hA000_0100);

    // Misaligned redirect coinciding with an ack.
    do_reset(0);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    check("mis_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      check("mis_flag", 32'(misalign), 32'd1);
      check("mis_req",  32'(imem_req), 32'd0);
      tick();
    end
`else
    check("mis_flag", 32'(misalign), 32'd0);
    check("mis_req",  32'(imem_req), 32'd1);
    check("mis_addr", imem_addr,     32'h100);
    tick();
    check("mis_ipc",   instr_pc,         32'h100);
    check("mis_valid2", 32'(instr_valid), 32'd1);
`endif

    // Asynchronous reset during a wait, then a stray ack.
    do_reset(3);
    repeat (5) tick();
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
    check("pre_rst_addr",  imem_addr,        32'h4);
    rst = 1'b0;
    #1;
    check_reset_vals("async");
    ack_force = 1'b1;
    tick();
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    tick();
    ack_force = 1'b0;
    check("late_ack_valid2", 32'(instr_valid), 32'd0);
    check("late_ack_addr",   imem_addr,        32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
